// File: rtl/mxm_result_collector.sv
// Collects one MxM result every N cycles into a FWFT FIFO and streams it row-major with row/matrix framing.
// Optional MXM_COLLECT_RELU_EN: treat y_in as signed and clamp negative results to zero at push time.
module mxm_result_collector #(
  parameter int W     = 8,
  parameter int N     = 1000,
  parameter int M     = 4,
  parameter int P     = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               y_in,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PHW = (N > 1) ? $clog2(N) : 1;
  localparam int CLW = (P > 1) ? $clog2(P) : 1;
  localparam int RWW = (M > 1) ? $clog2(M) : 1;

  if (N < 2) begin : g_bad_n
    $error("mxm_result_collector: N must be at least 2");
  end
  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("mxm_result_collector: DEPTH must be a power of 2 and at least 2");
  end

  logic [PHW-1:0] phase_r;
  logic           first_r;
  logic [CLW-1:0] col_r;
  logic [RWW-1:0] row_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           overflow_r;
  logic [W+1:0]   mem_r [DEPTH];

  logic           cap_s;
  logic           sample_s;
  logic           pop_s;
  logic           full_s;
  logic           push_s;
  logic           lost_s;
  logic           last_s;
  logic           done_s;
  logic [W-1:0]   data_s;
  logic [W+1:0]   head_s;

  // Capture, push/pop and framing-tag decode
  always_comb begin
    cap_s    = (phase_r == PHW'(1));
    sample_s = cap_s && !first_r;
    pop_s    = (count_r != {CW{1'b0}}) && out_ready;
    full_s   = (count_r == CW'(DEPTH));
    push_s   = sample_s && (!full_s || pop_s);
    lost_s   = sample_s && full_s && !pop_s;
    last_s   = (col_r == CLW'(P - 1));
    done_s   = last_s && (row_r == RWW'(M - 1));
`ifdef MXM_COLLECT_RELU_EN
    if (y_in[W-1]) begin
      data_s = {W{1'b0}};
    end else begin
      data_s = y_in;
    end
`else
    data_s = y_in;
`endif
  end

  // Free-running phase counter kept in lockstep with the MxM stage
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= {PHW{1'b0}};
    end else if (phase_r == PHW'(N - 1)) begin
      phase_r <= {PHW{1'b0}};
    end else begin
      phase_r <= phase_r + PHW'(1);
    end
  end

  // Framing, FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r    <= 1'b1;
      col_r      <= {CLW{1'b0}};
      row_r      <= {RWW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (cap_s) begin
        first_r <= 1'b0;
      end
      // Framing follows every sample slot, even a lost one, to stay aligned with the schedule
      if (sample_s) begin
        if (last_s) begin
          col_r <= {CLW{1'b0}};
          row_r <= (row_r == RWW'(M - 1)) ? {RWW{1'b0}} : row_r + RWW'(1);
        end else begin
          col_r <= col_r + CLW'(1);
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (lost_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= {done_s, last_s, data_s};
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign out_valid = (count_r != {CW{1'b0}});
  assign out_data  = head_s[W-1:0];
  assign out_last  = out_valid && head_s[W];
  assign out_done  = out_valid && head_s[W+1];
  assign overflow  = overflow_r;
  assign count     = count_r;

endmodule
